// File: rtl/mandel_pkg.sv
// Shared constants and palette codes for the Mandelbrot scanout slice.
package mandel_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned FB_DEPTH      = H_VISIBLE_DEF * V_VISIBLE_DEF;
  localparam int unsigned ITER_W        = 8;
  localparam int unsigned PIPE_LAT      = 2;

  typedef enum logic [1:0] {
    PAL_GRAY = 2'd0,
    PAL_FIRE = 2'd1,
    PAL_ICE  = 2'd2,
    PAL_BLUE = 2'd3
  } pal_e;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, old data on collision.
module fb_dpram #(
  parameter int unsigned Depth = 3072,
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem [Depth];

  // Read and write share one block so a same-address read returns the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/mandel_scanout.sv
// Framebuffer scanout: raster read, cycling palette lookup, and sync delay matched to the
// two-stage pixel pipeline.
module mandel_scanout
  import mandel_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned MAX_ITER  = 256,
  parameter int unsigned CYCLE_DIV = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              fb_we,
  input  logic [ADDR_W-1:0] fb_waddr,
  input  logic [7:0]        fb_wdata,
  input  logic              pix_valid,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              cycle_en,
  input  logic [1:0]        palette_sel,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned     FbDepth = H_VISIBLE * V_VISIBLE;
  localparam int unsigned     RamAw   = $clog2(FbDepth);
  localparam logic [ADDR_W:0] DepthX  = (ADDR_W + 1)'(FbDepth);
  localparam logic [ADDR_W-1:0] FbLast = ADDR_W'(FbDepth - 1);
  localparam logic [ITER_W-1:0] Inside = ITER_W'(MAX_ITER - 1);
  localparam logic [7:0]      DivLast = 8'(CYCLE_DIV - 1);

  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ITER_W-1:0]   iter_q;
  logic [ITER_W-1:0]   idx;
  logic [7:0]          phase_q, div_q, frame_q;
  pal_e                pal_q;
  logic [PIPE_LAT-1:0] hs_sr_q, vs_sr_q, pv_sr_q;
  logic [23:0]         rgb_q, rgb_d;
  logic                vs_edge, ram_we;

  assign vs_edge = vs_sr_q[0] & ~vs_in;
  assign ram_we  = fb_we && ({1'b0, fb_waddr} < DepthX);

  fb_dpram #(
    .Depth (FbDepth),
    .DataW (ITER_W),
    .AddrW (RamAw)
  ) u_fb (
    .clk_i   (CLOCK_50),
    .we_i    (ram_we),
    .waddr_i (fb_waddr[RamAw-1:0]),
    .wdata_i (fb_wdata),
    .raddr_i (raddr_q[RamAw-1:0]),
    .rdata_o (iter_q)
  );

  // Frame resync wins over a coincident pixel advance.
  always_comb begin
    raddr_d = raddr_q;
    if (vs_edge) begin
      raddr_d = '0;
    end else if (pix_valid) begin
      raddr_d = (raddr_q == FbLast) ? '0 : raddr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    idx   = iter_q + phase_q;
    rgb_d = '0;
    if (pv_sr_q[0] && (iter_q != Inside)) begin
      unique case (pal_q)
        PAL_GRAY: rgb_d = {idx, idx, idx};
        PAL_FIRE: rgb_d = {idx, idx[6:0], 1'b0, ~idx};
        PAL_ICE:  rgb_d = {~idx, idx, idx[3:0], 4'h0};
        PAL_BLUE: rgb_d = {16'h0000, idx};
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      raddr_q <= '0;
      hs_sr_q <= '1;
      vs_sr_q <= '1;
      pv_sr_q <= '0;
      rgb_q   <= '0;
    end else begin
      raddr_q <= raddr_d;
      hs_sr_q <= {hs_sr_q[PIPE_LAT-2:0], hs_in};
      vs_sr_q <= {vs_sr_q[PIPE_LAT-2:0], vs_in};
      pv_sr_q <= {pv_sr_q[PIPE_LAT-2:0], pix_valid};
      rgb_q   <= rgb_d;
    end
  end

  // Palette and phase only change at frame start so a frame is never drawn with mixed colours.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_q <= '0;
      phase_q <= '0;
      div_q   <= '0;
      pal_q   <= PAL_GRAY;
    end else if (vs_edge) begin
      frame_q <= frame_q + 8'd1;
      pal_q   <= pal_e'(palette_sel);
      if (cycle_en) begin
        if (div_q == DivLast) begin
          div_q   <= '0;
          phase_q <= phase_q + 8'd1;
        end else begin
          div_q <= div_q + 8'd1;
        end
      end
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_sr_q[PIPE_LAT-1];
  assign VGA_VS      = vs_sr_q[PIPE_LAT-1];
  assign VGA_BLANK_N = pv_sr_q[PIPE_LAT-1];
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_mandel_scanout.sv
// Directed bench for mandel_scanout on a 64x48 framebuffer.
module tb_mandel_scanout;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N;
  logic        fb_we;
  logic [18:0] fb_waddr;
  logic [7:0]  fb_wdata;
  logic        pix_valid, hs_in, vs_in, cycle_en;
  logic [1:0]  palette_sel;
  logic [7:0]  VGA_R, VGA_G, VGA_B, frame_cnt;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [23:0] rgb;

  int checks   = 0;
  int failures = 0;

  assign rgb = {VGA_R, VGA_G, VGA_B};

  always #5 CLOCK_50 = ~CLOCK_50;

  mandel_scanout #(
    .H_VISIBLE (64),
    .V_VISIBLE (48),
    .ADDR_W    (19),
    .MAX_ITER  (16),
    .CYCLE_DIV (2)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .fb_we       (fb_we),
    .fb_waddr    (fb_waddr),
    .fb_wdata    (fb_wdata),
    .pix_valid   (pix_valid),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .cycle_en    (cycle_en),
    .palette_sel (palette_sel),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .frame_cnt   (frame_cnt)
  );

  task automatic tick;
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d);
    fb_we    = 1'b1;
    fb_waddr = a;
    fb_wdata = d;
    tick();
    fb_we = 1'b0;
  endtask

  task automatic vs_pulse;
    vs_in = 1'b0;
    tick();
    vs_in = 1'b1;
    tick();
  endtask

  task automatic run_px(input int n);
    pix_valid = 1'b1;
    repeat (n) tick();
    pix_valid = 1'b0;
  endtask

  // One visible pixel; on return the RGB outputs show it.
  task automatic show_px;
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    hs_in = 1'b0; vs_in = 1'b0; pix_valid = 1'b1;
    repeat (3) tick();
    checks++;
    if (VGA_HS !== 1'b0) begin
      failures++; $display("FAIL pre_reset_hs got=%b exp=0", VGA_HS);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (rgb !== 24'h000000) begin
      failures++; $display("FAIL rst_rgb got=%h exp=000000", rgb);
    end
    checks++;
    if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1) begin
      failures++; $display("FAIL rst_sync got=%b%b exp=11", VGA_HS, VGA_VS);
    end
    checks++;
    if (VGA_BLANK_N !== 1'b0) begin
      failures++; $display("FAIL rst_blank got=%b exp=0", VGA_BLANK_N);
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      failures++; $display("FAIL rst_frame got=%0d exp=0", frame_cnt);
    end
    hs_in = 1'b1; vs_in = 1'b1; pix_valid = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    hs_in = 1'b0; vs_in = 1'b0; pix_valid = 1'b1;
    tick();
    checks++;
    if (VGA_HS !== 1'b1 || VGA_VS !== 1'b1 || VGA_BLANK_N !== 1'b0) begin
      failures++;
      $display("FAIL rel_lat1 got=%b%b%b exp=110", VGA_HS, VGA_VS, VGA_BLANK_N);
    end
    tick();
    checks++;
    if (VGA_HS !== 1'b0 || VGA_VS !== 1'b0 || VGA_BLANK_N !== 1'b1) begin
      failures++;
      $display("FAIL rel_lat2 got=%b%b%b exp=001", VGA_HS, VGA_VS, VGA_BLANK_N);
    end
    checks++;
    if (frame_cnt !== 8'd1) begin
      failures++; $display("FAIL rel_frame got=%0d exp=1", frame_cnt);
    end
    hs_in = 1'b1; vs_in = 1'b1; pix_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_basic;
    wr(19'd0, 8'd5);
    wr(19'd1, 8'd15);
    palette_sel = 2'd0;
    vs_pulse();
    pix_valid = 1'b1;
    tick();
    tick();
    checks++;
    if (rgb !== 24'h050505 || VGA_BLANK_N !== 1'b1) begin
      failures++; $display("FAIL basic_px0 got=%h/%b exp=050505/1", rgb, VGA_BLANK_N);
    end
    pix_valid = 1'b0;
    tick();
    checks++;
    if (rgb !== 24'h000000 || VGA_BLANK_N !== 1'b1) begin
      failures++; $display("FAIL basic_inside got=%h/%b exp=000000/1", rgb, VGA_BLANK_N);
    end
    tick();
    checks++;
    if (VGA_BLANK_N !== 1'b0) begin
      failures++; $display("FAIL basic_blank got=%b exp=0", VGA_BLANK_N);
    end
  endtask

  task automatic test_wrap;
    wr(19'd3071, 8'd3);
    wr(19'd100, 8'd8);
    wr(19'd101, 8'd9);
    vs_pulse();
    run_px(3071);
    show_px();
    checks++;
    if (rgb !== 24'h030303) begin
      failures++; $display("FAIL wrap_last got=%h exp=030303", rgb);
    end
    show_px();
    checks++;
    if (rgb !== 24'h050505) begin
      failures++; $display("FAIL wrap_first got=%h exp=050505", rgb);
    end
    run_px(99);
    vs_in = 1'b0; pix_valid = 1'b1;
    tick();
    vs_in = 1'b1; pix_valid = 1'b0;
    tick();
    checks++;
    if (rgb !== 24'h080808) begin
      failures++; $display("FAIL resync_px100 got=%h exp=080808", rgb);
    end
    show_px();
    checks++;
    if (rgb !== 24'h050505) begin
      failures++; $display("FAIL resync_px0 got=%h exp=050505", rgb);
    end
  endtask

  task automatic test_cycle;
    RESET_N = 1'b0;
    #1;
    tick();
    RESET_N = 1'b1;
    tick();
    cycle_en = 1'b1;
    vs_pulse();
    show_px();
    checks++;
    if (rgb !== 24'h050505) begin
      failures++; $display("FAIL cycle_div got=%h exp=050505", rgb);
    end
    repeat (3) vs_pulse();
    show_px();
    checks++;
    if (rgb !== 24'h070707) begin
      failures++; $display("FAIL cycle_phase2 got=%h exp=070707", rgb);
    end
    checks++;
    if (frame_cnt !== 8'd4) begin
      failures++; $display("FAIL cycle_frame4 got=%0d exp=4", frame_cnt);
    end
    cycle_en = 1'b0;
    repeat (2) vs_pulse();
    show_px();
    checks++;
    if (rgb !== 24'h070707) begin
      failures++; $display("FAIL cycle_hold got=%h exp=070707", rgb);
    end
    checks++;
    if (frame_cnt !== 8'd6) begin
      failures++; $display("FAIL cycle_frame6 got=%0d exp=6", frame_cnt);
    end
  endtask

  task automatic test_palette;
    wr(19'd1, 8'd4);
    palette_sel = 2'd3;
    show_px();
    checks++;
    if (rgb !== 24'h060606) begin
      failures++; $display("FAIL pal_midframe got=%h exp=060606", rgb);
    end
    vs_pulse();
    show_px();
    checks++;
    if (rgb !== 24'h000007) begin
      failures++; $display("FAIL pal_blue got=%h exp=000007", rgb);
    end
    palette_sel = 2'd1;
    vs_pulse();
    show_px();
    checks++;
    if (rgb !== 24'h070ef8) begin
      failures++; $display("FAIL pal_fire got=%h exp=070ef8", rgb);
    end
    palette_sel = 2'd2;
    vs_pulse();
    show_px();
    checks++;
    if (rgb !== 24'hf80770) begin
      failures++; $display("FAIL pal_ice got=%h exp=f80770", rgb);
    end
  endtask

  task automatic test_oob_collision;
    palette_sel = 2'd0;
    wr(19'd3072, 8'd1);
    wr(19'd4096, 8'd1);
    vs_pulse();
    show_px();
    checks++;
    if (rgb !== 24'h070707) begin
      failures++; $display("FAIL oob_write got=%h exp=070707", rgb);
    end
    wr(19'd7, 8'd3);
    vs_pulse();
    run_px(7);
    fb_we = 1'b1; fb_waddr = 19'd7; fb_wdata = 8'd9; pix_valid = 1'b1;
    tick();
    fb_we = 1'b0; pix_valid = 1'b0;
    tick();
    checks++;
    if (rgb !== 24'h050505) begin
      failures++; $display("FAIL collide_old got=%h exp=050505", rgb);
    end
    vs_pulse();
    run_px(7);
    show_px();
    checks++;
    if (rgb !== 24'h0b0b0b) begin
      failures++; $display("FAIL collide_new got=%h exp=0b0b0b", rgb);
    end
  endtask

  initial begin
    RESET_N     = 1'b0;
    fb_we       = 1'b0;
    fb_waddr    = '0;
    fb_wdata    = '0;
    pix_valid   = 1'b0;
    hs_in       = 1'b1;
    vs_in       = 1'b1;
    cycle_en    = 1'b0;
    palette_sel = 2'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_cycle();
    test_palette();
    test_oob_collision();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
